// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: M-stage data-bus controller for the five-stage MIPS pipeline.
// Builds the dbus request (size, byte strobes, lane-replicated store data),
// holds it until data_ok, extends load data and parks a completed response
// while the M stage is frozen. busy is the data-bus stall term.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses (addr_err) instead of silently clearing the low address bits.

package common_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module mem_access_ctrl
    import common_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        advance,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ADDR,
        S_WAIT_DATA,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] hold_buf;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        err;
    logic [31:0] req_addr;
    logic        want_req;
    logic        handshake;

    // Size 3 is illegal and behaves as a word access.
    assign is_byte = (mem_size == 2'd0);
    assign is_half = (mem_size == 2'd1);
    assign is_word = mem_size[1];

`ifdef MEM_ALIGN_CHECK_EN
    assign err      = (is_half & mem_addr[0]) | (is_word & (|mem_addr[1:0]));
    assign req_addr = mem_addr;
    assign addr_err = ~reset & mem_en & err;
`else
    assign err      = 1'b0;
    assign req_addr = {mem_addr[31:2], mem_addr[1] & ~is_word, mem_addr[0] & is_byte};
    assign addr_err = 1'b0;
`endif

    // A request is live while waiting on the bus, or from the first cycle the
    // instruction sits in M; reset kills it in the same cycle.
    assign want_req  = (state == S_WAIT_ADDR) || (state == S_WAIT_DATA) ||
                       ((state == S_IDLE) && mem_en && !err);
    assign handshake = dreq.valid & dresp.data_ok;

    // No path from advance here, so the hazard unit sees no combinational loop.
    assign busy = dreq.valid & ~dresp.data_ok;
    assign done = ~reset & (handshake | (state == S_HOLD) | (mem_en & err));

    // Select the addressed lane of a bus word and sign/zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*mem_addr[1:0] +: 8];
        h = mem_addr[1] ? word[31:16] : word[15:0];
        if (is_byte)
            return {{24{b[7] & ~mem_unsigned}}, b};
        else if (is_half)
            return {{16{h[15] & ~mem_unsigned}}, h};
        else
            return word;
    endfunction

    // Request fields: aligned address, size code, byte strobes, replicated store data.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        dreq        = '0;
        dreq.valid  = want_req & ~reset;
        dreq.addr   = req_addr;
        dreq.size   = MSIZE4;
        dreq.strobe = 4'h0;
        dreq.data   = mem_wdata;
        if (is_byte) begin
            dreq.size = MSIZE1;
            dreq.data = {4{mem_wdata[7:0]}};
            if (mem_write) dreq.strobe = 4'b0001 << mem_addr[1:0];
        end else if (is_half) begin
            dreq.size = MSIZE2;
            dreq.data = {2{mem_wdata[15:0]}};
            if (mem_write) dreq.strobe = 4'b0011 << {mem_addr[1], 1'b0};
        end else begin
            if (mem_write) dreq.strobe = 4'hf;
        end
    end

    // Load result: live bus data on the completing cycle, buffered word while frozen.
    always_comb begin
        rdata = '0;
        if (!reset) begin
            if (state == S_HOLD)
                rdata = load_extend(hold_buf);
            else if (handshake)
                rdata = load_extend(dresp.data);
        end
    end

    // Request tracking FSM plus the buffer for a response completed under a freeze.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= S_IDLE;
            // NOTE: the response buffer is a plain register, cleared so HOLD never exposes stale data after reset.
            hold_buf <= '0;
        end else begin
            case (state)
                S_IDLE, S_WAIT_ADDR, S_WAIT_DATA: begin
                    if (dreq.valid) begin
                        if (dresp.data_ok) begin
                            if (advance) begin
                                state <= S_IDLE;
                            end else begin
                                state    <= S_HOLD;
                                hold_buf <= dresp.data;
                            end
                        end else if (dresp.addr_ok || (state == S_WAIT_DATA)) begin
                            state <= S_WAIT_DATA;
                        end else begin
                            state <= S_WAIT_ADDR;
                        end
                    end
                end
                S_HOLD: begin
                    if (advance) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed test-plan cases followed by randomized
// load/store transactions with random bus wait states and M-stage freezes,
// checked against a per-transaction reference model.
`timescale 1ns/1ps

module tb_mem_access_ctrl;
    import common_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        advance;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .mem_en       (mem_en),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .advance      (advance),
        .dreq         (dreq),
        .dresp        (dresp),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .addr_err     (addr_err)
    );

    // Upstream must never advance the M stage while the bus stalls it.
    always @(posedge clk) begin
        assert (reset || !(advance && busy))
            else $error("protocol violation: advance while busy");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_addr(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return a;
`else
        if (sz == 2'd0) return a;
        if (sz == 2'd1) return a - (a % 2);
        return a - (a % 4);
`endif
    endfunction

    function automatic logic [31:0] exp_size(input logic [1:0] sz);
        if (sz == 2'd0) return 32'(MSIZE1);
        if (sz == 2'd1) return 32'(MSIZE2);
        return 32'(MSIZE4);
    endfunction

    function automatic logic [31:0] exp_strobe(input logic wr, input logic [1:0] sz, input logic [31:0] a);
        if (!wr) return 32'h0;
        if (sz == 2'd0) return 32'h1 << (a % 4);
        if (sz == 2'd1) return 32'h3 << (2 * ((a / 2) % 2));
        return 32'hf;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        mem_en        = 1'b0;
        advance       = 1'b0;
        dresp.addr_ok = 1'($urandom);
        dresp.data_ok = 1'b0;
        dresp.data    = $urandom;
        @(negedge clk);
        check("idle_valid", 32'(dreq.valid), 32'd0);
        check("idle_busy",  32'(busy),       32'd0);
        check("idle_done",  32'(done),       32'd0);
        next_cycle();
    endtask

    // One M-stage access: addr_ok rises after wa cycles, data_ok arrives after n
    // wait cycles, then the M stage stays frozen for h more cycles.
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wdat,
                           input logic [31:0] bus, input int wa, input int n, input int h);
        logic [31:0] exp_rd;
        mem_en       = 1'b1;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        mem_addr     = a;
        mem_wdata    = wdat;
        exp_rd       = exp_load(sz, uns, a, bus);

        if (exp_err(sz, a)) begin
            for (int k = 0; k < 2; k++) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = $urandom;
                advance       = (k == 1);
                @(negedge clk);
                check("err_valid", 32'(dreq.valid), 32'd0);
                check("err_flag",  32'(addr_err),   32'd1);
                check("err_done",  32'(done),       32'd1);
                check("err_busy",  32'(busy),       32'd0);
                check("err_rdata", rdata,           32'd0);
                next_cycle();
            end
            return;
        end

        for (int k = 0; k <= n; k++) begin
            dresp.addr_ok = (k >= wa);
            dresp.data_ok = (k == n);
            dresp.data    = (k == n) ? bus : $urandom;
            advance       = (k == n) && (h == 0);
            @(negedge clk);
            check("valid",  32'(dreq.valid),  32'd1);
            check("busy",   32'(busy),        32'(k < n));
            check("done",   32'(done),        32'(k == n));
            check("addr",   dreq.addr,        exp_addr(sz, a));
            check("size",   32'(dreq.size),   exp_size(sz));
            check("strobe", 32'(dreq.strobe), exp_strobe(wr, sz, a));
            check("aerr",   32'(addr_err),    32'd0);
            if (wr) check("wdata", dreq.data, exp_wdata(sz, wdat));
            if (!wr && k == n) check("rdata", rdata, exp_rd);
            next_cycle();
        end

        for (int j = 1; j <= h; j++) begin
            dresp.addr_ok = 1'($urandom);
            dresp.data_ok = 1'($urandom);
            dresp.data    = $urandom;
            advance       = (j == h);
            @(negedge clk);
            check("hold_valid", 32'(dreq.valid), 32'd0);
            check("hold_busy",  32'(busy),       32'd0);
            check("hold_done",  32'(done),       32'd1);
            if (!wr) check("hold_rdata", rdata, exp_rd);
            next_cycle();
        end
        advance = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        mem_en        = 1'b1;
        mem_write     = 1'b0;
        mem_size      = 2'd2;
        mem_unsigned  = 1'b0;
        mem_addr      = 32'h1000;
        mem_wdata     = 32'h0;
        advance       = 1'b0;
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = 32'hDEAD_BEEF;
        #1;
        next_cycle();
        next_cycle();
        // Reset holds every output low even with a request pending and a ready bus.
        @(negedge clk);
        check("rst_valid", 32'(dreq.valid), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_rdata", rdata,           32'd0);
        check("rst_aerr",  32'(addr_err),   32'd0);
        next_cycle();
        reset = 1'b0;

        idle_cycle();
        // Zero-wait lw.
        run_txn(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h8000_00F0, 0, 0, 0);
        // sb with three wait cycles.
        run_txn(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_005A, 32'h0, 1, 3, 0);
        // Load extension cases.
        run_txn(1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 32'h0000_8000, 0, 1, 0);
        run_txn(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 32'h0000_8000, 0, 0, 0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_0000, 2, 2, 0);
        // Completed load parked for two frozen cycles.
        run_txn(1'b0, 2'd2, 1'b0, 32'h3004, 32'h0, 32'h1234_5678, 0, 1, 2);
        // Misaligned word: rejected with the check, issued at 0x1000 without it.
        run_txn(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
        idle_cycle();

        // Reset in WAIT_DATA abandons the access; the same access then reissues.
        mem_en = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
        mem_addr = 32'h4008; mem_wdata = 32'h0; advance = 1'b0;
        dresp.addr_ok = 1'b1; dresp.data_ok = 1'b0; dresp.data = $urandom;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(dreq.valid), 32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        next_cycle();
        reset = 1'b0;
        run_txn(1'b0, 2'd2, 1'b0, 32'h4008, 32'h0, 32'h0BAD_CAFE, 1, 2, 0);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          n;
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) a = a & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
            n = $urandom_range(0, 4);
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                    $urandom_range(0, n), n, $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
